// File: rtl/mult_div_unit.sv
// mult_div_unit: EX-stage multiply/divide unit with HI/LO registers.
// Launches MULT/MULTU/DIV/DIVU on Start, holds Busy for a fixed latency and
// commits the shadow result into HI/LO on the edge Busy falls.
// Optional feature macro: MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU (ops 9-12).
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous active-low reset
//   A, B   - rs/rt operands (32b)
//   MDOp   - operation select (4b)
//   Start  - one-cycle launch strobe for multi-cycle ops
//   Busy   - high while an operation is in flight
//   HI, LO - architectural HI/LO registers
//   MDOut  - MFHI/MFLO read data (combinational from HI/LO)
module mult_div_unit #(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  MDOp,
  input  logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDOut
);

  localparam int unsigned MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;
`endif

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic               r_wr;
  logic [31:0]        r_hi;
  logic [31:0]        r_lo;
  logic [31:0]        r_tmp_hi;
  logic [31:0]        r_tmp_lo;

  logic [63:0]        w_prod_s;
  logic [63:0]        w_prod_u;
  logic               w_div_ovf;
  logic signed [31:0] w_a_s;
  logic signed [31:0] w_b_s;
  logic signed [31:0] w_quo_s;
  logic signed [31:0] w_rem_s;
  logic [31:0]        w_b_u;
  logic [31:0]        w_quo_u;
  logic [31:0]        w_rem_u;
  logic               w_is_launch_op;
  logic [CNT_W-1:0]   w_cycles;
  logic [63:0]        w_tmp;
  logic               w_write;
  logic               w_launch;

  // Lower 64 bits of sign-extended operands equal the signed 32x32 product.
  assign w_prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign w_prod_u = {32'd0, A} * {32'd0, B};

  // Divisor forced to 1 for /0 (result discarded) and for MIN/-1, where
  // dividing by 1 yields exactly the wrapped answer (q=MIN, r=0).
  assign w_div_ovf = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
  assign w_a_s     = $signed(A);
  assign w_b_s     = ((B == 32'd0) || w_div_ovf) ? 32'sd1 : $signed(B);
  assign w_quo_s   = w_a_s / w_b_s;
  assign w_rem_s   = w_a_s % w_b_s;
  assign w_b_u     = (B == 32'd0) ? 32'd1 : B;
  assign w_quo_u   = A / w_b_u;
  assign w_rem_u   = A % w_b_u;

  // Operation decode: latency, shadow result and whether it commits.
  always_comb begin
    w_is_launch_op = 1'b0;
    w_cycles       = '0;
    w_tmp          = '0;
    w_write        = 1'b0;
    case (MDOp)
      OP_MULT: begin
        w_is_launch_op = 1'b1;
        w_cycles       = CNT_W'(MUL_CYCLES);
        w_tmp          = w_prod_s;
        w_write        = 1'b1;
      end
      OP_MULTU: begin
        w_is_launch_op = 1'b1;
        w_cycles       = CNT_W'(MUL_CYCLES);
        w_tmp          = w_prod_u;
        w_write        = 1'b1;
      end
      OP_DIV: begin
        w_is_launch_op = 1'b1;
        w_cycles       = CNT_W'(DIV_CYCLES);
        w_tmp          = {w_rem_s, w_quo_s};
        w_write        = (B != 32'd0);
      end
      OP_DIVU: begin
        w_is_launch_op = 1'b1;
        w_cycles       = CNT_W'(DIV_CYCLES);
        w_tmp          = {w_rem_u, w_quo_u};
        w_write        = (B != 32'd0);
      end
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
        w_is_launch_op = 1'b1;
        w_cycles       = CNT_W'(MUL_CYCLES);
        w_write        = 1'b1;
        case (MDOp)
          OP_MADD:  w_tmp = {r_hi, r_lo} + w_prod_s;
          OP_MADDU: w_tmp = {r_hi, r_lo} + w_prod_u;
          OP_MSUB:  w_tmp = {r_hi, r_lo} - w_prod_s;
          default:  w_tmp = {r_hi, r_lo} - w_prod_u;
        endcase
      end
`endif
      default: ;
    endcase
  end

  assign w_launch = Start && !r_busy && w_is_launch_op;

  // Control FSM plus HI/LO and shadow registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_wr     <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_tmp_hi <= '0;
      r_tmp_lo <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_launch) begin
            r_tmp_hi <= w_tmp[63:32];
            r_tmp_lo <= w_tmp[31:0];
            r_wr     <= w_write;
            r_cnt    <= w_cycles;
            r_busy   <= 1'b1;
            r_state  <= S_RUN;
          end else if (MDOp == OP_MTHI) begin
            r_hi <= A;
          end else if (MDOp == OP_MTLO) begin
            r_lo <= A;
          end
        end
        default: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            if (r_wr) begin
              r_hi <= r_tmp_hi;
              r_lo <= r_tmp_lo;
            end
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign Busy  = r_busy;
  assign HI    = r_hi;
  assign LO    = r_lo;
  assign MDOut = (MDOp == OP_MFHI) ? r_hi :
                 (MDOp == OP_MFLO) ? r_lo : 32'd0;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed scenarios with literal expectations plus
// randomized traffic, all checked each cycle against an arithmetic model.
module tb_mult_div_unit;

  localparam int unsigned MULC = 5;
  localparam int unsigned DIVC = 10;

  logic        clk;
  logic        reset;
  logic [31:0] A, B;
  logic [3:0]  MDOp;
  logic        Start;
  logic        Busy;
  logic [31:0] HI, LO, MDOut;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: architectural regs, cycles left busy, pending result.
  logic [31:0] m_hi, m_lo;
  int          m_left;
  logic [63:0] m_pend;
  logic        m_wr;

  mult_div_unit #(.MUL_CYCLES(MULC), .DIV_CYCLES(DIVC)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .MDOp(MDOp), .Start(Start),
    .Busy(Busy), .HI(HI), .LO(LO), .MDOut(MDOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic [31:0] exp_md;
    exp_md = (MDOp == 4'd7) ? m_hi : (MDOp == 4'd8) ? m_lo : 32'd0;
    cmp("busy",  {31'd0, Busy}, {31'd0, (m_left > 0)});
    cmp("hi",    HI, m_hi);
    cmp("lo",    LO, m_lo);
    cmp("mdout", MDOut, exp_md);
  endtask

  function automatic bit is_mdu_launch(input logic [3:0] op);
`ifdef MDU_MADD_EN
    return (op >= 4'd1 && op <= 4'd4) || (op >= 4'd9 && op <= 4'd12);
`else
    return (op >= 4'd1 && op <= 4'd4);
`endif
  endfunction

  // Reference arithmetic using 64-bit integer math.
  task automatic ref_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [63:0] res, output logic wr, output int lat);
    longint sa, sb, q, r;
    longint unsigned ua, ub, acc;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = {32'd0, a};          ub = {32'd0, b};
    acc = {m_hi, m_lo};
    wr = 1'b1; lat = MULC; res = '0;
    case (op)
      4'd1: res = 64'(sa * sb);
      4'd2: res = 64'(ua * ub);
      4'd3, 4'd4: begin
        lat = DIVC;
        if (b == 32'd0) wr = 1'b0;
        else if (op == 4'd3) begin
          q = sa / sb; r = sa % sb;
          res = {r[31:0], q[31:0]};
        end else begin
          res = {32'(ua % ub), 32'(ua / ub)};
        end
      end
      4'd9:  res = 64'(acc + 64'(sa * sb));
      4'd10: res = 64'(acc + ua * ub);
      4'd11: res = 64'(acc - 64'(sa * sb));
      default: res = 64'(acc - ua * ub);
    endcase
  endtask

  // Advance the model across one rising edge for the currently driven inputs.
  task automatic model_edge();
    logic [63:0] res; logic wr; int lat;
    if (m_left > 0) begin
      if (m_left == 1 && m_wr) begin
        m_hi = m_pend[63:32];
        m_lo = m_pend[31:0];
      end
      m_left--;
    end else if (Start && is_mdu_launch(MDOp)) begin
      ref_op(MDOp, A, B, res, wr, lat);
      m_pend = res; m_wr = wr; m_left = lat;
    end else if (MDOp == 4'd5) m_hi = A;
    else if (MDOp == 4'd6) m_lo = A;
  endtask

  // Called at a negedge: check, drive, model the edge, move to next negedge.
  task automatic cycle(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic st);
    check_outputs();
    MDOp = op; A = a; B = b; Start = st;
    model_edge();
    @(negedge clk);
  endtask

  task automatic model_clear();
    m_hi = '0; m_lo = '0; m_left = 0; m_pend = '0; m_wr = 1'b0;
  endtask

  task automatic run_until_idle(output int n);
    n = 0;
    while (Busy === 1'b1 && n < 50) begin
      n++;
      cycle(4'd0, 32'd0, 32'd0, 1'b0);
    end
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] corners [5];
    corners[0] = 32'h0; corners[1] = 32'h1; corners[2] = 32'hFFFF_FFFF;
    corners[3] = 32'h8000_0000; corners[4] = 32'h7FFF_FFFF;
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
    return $urandom();
  endfunction

  initial begin
    int n;
    logic [31:0] sv_hi, sv_lo;
    reset = 1'b0; A = '0; B = '0; MDOp = '0; Start = 1'b0;
    model_clear();
    @(negedge clk); @(negedge clk);
    cmp("reset_busy", {31'd0, Busy}, 32'd0);
    cmp("reset_hi", HI, 32'd0);
    cmp("reset_lo", LO, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // 1: MULT signed
    cycle(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b1);
    cycle(4'd0, 32'd0, 32'd0, 1'b0);
    cmp("t1_busy_len", 32'(n) + 32'd1, 32'd1); // n is still 0 here
    run_until_idle(n);
    cmp("t1_busy_len", 32'(n), 32'(MULC - 1));
    cmp("t1_hi", HI, 32'hFFFF_FFFF);
    cmp("t1_lo", LO, 32'hFFFF_FFFA);

    // 2: MULTU
    cycle(4'd2, 32'hFFFF_FFFE, 32'd3, 1'b1);
    run_until_idle(n);
    cmp("t2_busy_len", 32'(n), 32'(MULC));
    cmp("t2_hi", HI, 32'h0000_0002);
    cmp("t2_lo", LO, 32'hFFFF_FFFA);

    // 3: DIV signed, DIVU by zero, MIN/-1
    cycle(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b1);
    run_until_idle(n);
    cmp("t3_busy_len", 32'(n), 32'(DIVC));
    cmp("t3_lo", LO, 32'hFFFF_FFFD);
    cmp("t3_hi", HI, 32'hFFFF_FFFF);
    cycle(4'd4, 32'd7, 32'd0, 1'b1);
    run_until_idle(n);
    cmp("t3_div0_len", 32'(n), 32'(DIVC));
    cmp("t3_div0_lo", LO, 32'hFFFF_FFFD);
    cmp("t3_div0_hi", HI, 32'hFFFF_FFFF);
    cycle(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    run_until_idle(n);
    cmp("t3_ovf_lo", LO, 32'h8000_0000);
    cmp("t3_ovf_hi", HI, 32'h0);

    // 4: MTHI/MFHI, MTLO and Start while busy
    cycle(4'd5, 32'h1234_5678, 32'd0, 1'b0);
    cycle(4'd7, 32'd0, 32'd0, 1'b0);
    cmp("t4_hi", HI, 32'h1234_5678);
    cmp("t4_mfhi", MDOut, 32'h1234_5678);
    sv_lo = LO;
    cycle(4'd1, 32'd2, 32'd3, 1'b1);
    cycle(4'd6, 32'hDEAD_BEEF, 32'd0, 1'b0);
    cycle(4'd3, 32'd100, 32'd7, 1'b1);
    cmp("t4_mtlo_busy", LO, sv_lo);
    run_until_idle(n);
    cmp("t4_len", 32'(n), 32'(MULC - 2));
    cmp("t4_lo", LO, 32'd6);

    // 5: reset in the third busy cycle of a DIV
    cycle(4'd3, 32'd1000, 32'd7, 1'b1);
    cycle(4'd7, 32'd0, 32'd0, 1'b0);
    cycle(4'd7, 32'd0, 32'd0, 1'b0);
    cmp("t5_busy_pre", {31'd0, Busy}, 32'd1);
    #2 reset = 1'b0;
    #1;
    model_clear();
    cmp("t5_busy", {31'd0, Busy}, 32'd0);
    cmp("t5_hi", HI, 32'd0);
    cmp("t5_lo", LO, 32'd0);
    cmp("t5_mdout", MDOut, 32'd0);
    MDOp = 4'd0; Start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < DIVC + 2; i++) cycle(4'd8, 32'd0, 32'd0, 1'b0);
    cmp("t5_after_lo", LO, 32'd0);

    // 6: multiply-accumulate ops
    cycle(4'd6, 32'hFFFF_FFFF, 32'd0, 1'b0);
    cycle(4'd9, 32'd1, 32'd1, 1'b1);
`ifdef MDU_MADD_EN
    run_until_idle(n);
    cmp("t6_len", 32'(n), 32'(MULC));
    cmp("t6_hi", HI, 32'd1);
    cmp("t6_lo", LO, 32'd0);
`else
    cmp("t6_nobusy", {31'd0, Busy}, 32'd0);
    cmp("t6_hi", HI, 32'd0);
    cmp("t6_lo", LO, 32'hFFFF_FFFF);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 12));
      cycle(op, pick_operand(), pick_operand(), 1'($urandom_range(0, 1)));
    end
    run_until_idle(n);
    check_outputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
